// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: op encodings, FSM states, widths.
package alu_seq_pkg;

    localparam int OPND_W         = 8;
    localparam int RES_W          = 16;
    localparam int CNT_W          = 4;   // holds SETTLE values 1..15
    localparam int SETTLE_DEFAULT = 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_EXP = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // A request is refused locally when the op code is unused or it would divide by zero.
    function automatic logic op_rejected(input logic [2:0] op, input logic [OPND_W-1:0] b);
        return (op > OP_EXP) || ((op == OP_DIV) && (b == '0));
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Registered initiator for the combinational 8-bit signed ALU: accepts a request,
// holds operands and one op line for SETTLE cycles, captures the result and
// returns it over a valid/ready response channel.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [OPND_W-1:0] req_a,
    input  logic [OPND_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_ovf,
    output logic              rsp_err,
    output logic [OPND_W-1:0] alu_k,
    output logic [OPND_W-1:0] alu_m,
    output logic              alu_add,
    output logic              alu_sub,
    output logic              alu_mul,
    output logic              alu_div,
    output logic              alu_exp,
    input  logic [RES_W-1:0]  alu_r,
    input  logic              alu_ovf,
    output logic [7:0]        op_count,
    output logic [7:0]        err_count
);

    state_t             state;
    logic [2:0]         op_reg;
    logic [CNT_W-1:0]   settle_cnt;

    // Handshake readiness follows directly from the registered state.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // One-hot op lines: decode of the registered op, only while in ISSUE.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        alu_add = 1'b0;
        alu_sub = 1'b0;
        alu_mul = 1'b0;
        alu_div = 1'b0;
        alu_exp = 1'b0;
        if (state == ISSUE) begin
            case (op_reg)
                OP_ADD:  alu_add = 1'b1;
                OP_SUB:  alu_sub = 1'b1;
                OP_MUL:  alu_mul = 1'b1;
                OP_DIV:  alu_div = 1'b1;
                OP_EXP:  alu_exp = 1'b1;
                default: ;
            endcase
        end
    end

    // Sequencer FSM with registered operands, response fields and counters.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            op_reg     <= OP_ADD;
            settle_cnt <= '0;
            alu_k      <= '0;
            alu_m      <= '0;
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (op_rejected(req_op, req_b)) begin
                            // Operands are left alone so the ALU never sees a refused request.
                            rsp_result <= '0;
                            rsp_ovf    <= 1'b0;
                            rsp_err    <= 1'b1;
                            state      <= RESP;
                        end else begin
                            alu_k      <= req_a;
                            alu_m      <= req_b;
                            op_reg     <= req_op;
                            settle_cnt <= CNT_W'(SETTLE);
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (settle_cnt == CNT_W'(1)) begin
                        rsp_result <= alu_r;
                        rsp_ovf    <= alu_ovf;
                        rsp_err    <= 1'b0;
                        state      <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 8'd1;
                        if (rsp_err && (err_count != 8'hFF)) begin
                            err_count <= err_count + 8'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
